pmem_arbiter: RTL and testbench

//   Shares one physical-memory port between the split L1 I-cache and D-cache of the
//   LC-3b pipeline. Each cache's pmem_* side connects here instead of to memory;
//   the arbiter grants one line-sized transaction at a time, latches it, drives memory,
//   and routes the response back to the owner. D-cache has priority, with an I-cache

---
 rtl/pmem_arbiter_pkg.sv | 18 +
 rtl/pmem_arbiter.sv | 104 ++++++++++
 tb/tb_pmem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the LC-3b L1 I/D physical-memory arbiter.
package pmem_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] cache_line;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ICACHE = 2'd1,
    ARB_DCACHE = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_OP_READ  = 1'b0,
    ARB_OP_WRITE = 1'b1
  } arb_op_t;

endpackage

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache: one latched
// line transaction at a time, D-cache priority with an I-cache anti-starvation limit.
module pmem_arbiter
  import pmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_pmem_read,
  input  lc3b_word  i_pmem_address,
  output cache_line i_pmem_rdata,
  output logic      i_pmem_resp,
  input  logic      d_pmem_read,
  input  logic      d_pmem_write,
  input  lc3b_word  d_pmem_address,
  input  cache_line d_pmem_wdata,
  output cache_line d_pmem_rdata,
  output logic      d_pmem_resp,
  output logic      pmem_read,
  output logic      pmem_write,
  output lc3b_word  pmem_address,
  output cache_line pmem_wdata,
  input  cache_line pmem_rdata,
  input  logic      pmem_resp,
  output logic      arb_conflict
);

  localparam int unsigned        CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]   STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state, state_next;
  arb_op_t          op_q;
  lc3b_word         addr_q;
  cache_line        wdata_q;
  logic [CNT_W-1:0] starve_cnt;

  logic d_req, idle, owned, starved, grant_d, grant_i;

  assign d_req   = d_pmem_read | d_pmem_write;
  assign idle    = (state == ARB_IDLE);
  assign owned   = (state == ARB_ICACHE) | (state == ARB_DCACHE);
  assign starved = (starve_cnt == STARVE_MAX);

  // D wins every contest except when I has waited through STARVE_LIMIT D grants.
  assign grant_d = idle & d_req & ~(i_pmem_read & starved);
  assign grant_i = idle & i_pmem_read & ~grant_d;

  always_comb begin
    // NOTE: default assignment first so every path drives state_next and no latch is inferred.
    state_next = state;
    case (state)
      ARB_IDLE: begin
        if (grant_d)      state_next = ARB_DCACHE;
        else if (grant_i) state_next = ARB_ICACHE;
      end
      ARB_ICACHE, ARB_DCACHE: begin
        if (pmem_resp) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      op_q       <= ARB_OP_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      starve_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      if (grant_d) begin
        addr_q <= d_pmem_address;
        op_q   <= d_pmem_write ? ARB_OP_WRITE : ARB_OP_READ;
        if (d_pmem_write) wdata_q <= d_pmem_wdata;
        if (!i_pmem_read)  starve_cnt <= '0;
        else if (!starved) starve_cnt <= starve_cnt + 1'b1;
      end else if (grant_i) begin
        addr_q     <= i_pmem_address;
        op_q       <= ARB_OP_READ;
        starve_cnt <= '0;
      end
    end
  end

  // Memory sees only the latched request, so requester inputs may move mid-transaction.
  assign pmem_read    = owned & (op_q == ARB_OP_READ);
  assign pmem_write   = owned & (op_q == ARB_OP_WRITE);
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  assign i_pmem_resp  = (state == ARB_ICACHE) & pmem_resp;
  assign d_pmem_resp  = (state == ARB_DCACHE) & pmem_resp;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  assign arb_conflict = ~reset & idle & i_pmem_read & d_req;

  // A simultaneous D read and write is a cache-controller bug; it is served as a write.
  assert property (@(posedge clk) disable iff (reset) !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomized bench for pmem_arbiter: cache agents and a memory model drive the DUT,
// a transaction-level reference model predicts every output cycle by cycle.
module tb_pmem_arbiter;
  import pmem_arbiter_pkg::*;

  localparam int  LIMIT = 4;
  localparam byte RI    = 8'h49;
  localparam byte RD    = 8'h44;
  localparam cache_line T2_WDATA = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;

  logic      clk, reset;
  logic      i_pmem_read;
  lc3b_word  i_pmem_address;
  cache_line i_pmem_rdata;
  logic      i_pmem_resp;
  logic      d_pmem_read, d_pmem_write;
  lc3b_word  d_pmem_address;
  cache_line d_pmem_wdata, d_pmem_rdata;
  logic      d_pmem_resp;
  logic      pmem_read, pmem_write;
  lc3b_word  pmem_address;
  cache_line pmem_wdata, pmem_rdata;
  logic      pmem_resp;
  logic      arb_conflict;

  pmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .arb_conflict(arb_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Environment: memory contents, latency and cache-agent behaviour.
  cache_line phys [lc3b_word];
  cache_line model_mem [lc3b_word];
  int  mem_cnt = 0, mem_lat = 1, fixed_lat = 5;
  int  i_rate = 0, d_rate = 0;
  bit  mutate = 1'b0;
  bit  i_done = 1'b0, d_done = 1'b0;
  bit  inj_i = 1'b0, inj_d = 1'b0, inj_d_write = 1'b0, inj_addr_change = 1'b0;
  lc3b_word  inj_i_addr, inj_d_addr, inj_new_addr;
  cache_line inj_d_wdata;

  // Reference model: who owns memory now, what was latched, and the starvation count.
  int        m_owner = 0;  // 0 none, 1 I-cache, 2 D-cache
  lc3b_word  m_addr  = '0;
  bit        m_write = 1'b0;
  cache_line m_wdata = '0;
  int        m_starve = 0;

  byte       resp_log[$];
  cache_line i_last_line, d_last_line;
  bit        conflict_seen = 1'b0;

  function automatic cache_line seed_line(input lc3b_word a);
    return {4{a ^ 16'h5A5A, a}};
  endfunction

  function automatic cache_line phys_rd(input lc3b_word a);
    return phys.exists(a) ? phys[a] : seed_line(a);
  endfunction

  function automatic cache_line model_rd(input lc3b_word a);
    return model_mem.exists(a) ? model_mem[a] : seed_line(a);
  endfunction

  function automatic lc3b_word rand_addr();
    return lc3b_word'($urandom_range(0, 31) << 4);
  endfunction

  function automatic cache_line rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive();
    pmem_resp  = 1'b0;
    pmem_rdata = rand_line();
    if (pmem_read || pmem_write) begin
      mem_cnt++;
      if (mem_cnt == 1) mem_lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 6));
      if (mem_cnt >= mem_lat) begin
        pmem_resp = 1'b1;
        mem_cnt   = 0;
        if (pmem_write) phys[pmem_address] = pmem_wdata;
        else            pmem_rdata = phys_rd(pmem_address);
      end
    end else begin
      mem_cnt = 0;
    end

    if (i_done) begin i_pmem_read = 1'b0; i_done = 1'b0; end
    if (d_done) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_done = 1'b0; end
    if (mutate && i_pmem_read && $urandom_range(0, 9) == 0) i_pmem_address = rand_addr();
    if (mutate && (d_pmem_read || d_pmem_write) && $urandom_range(0, 9) == 0) begin
      d_pmem_address = rand_addr();
      d_pmem_wdata   = rand_line();
    end
    if (!i_pmem_read && $urandom_range(0, 99) < i_rate) begin
      i_pmem_read    = 1'b1;
      i_pmem_address = rand_addr();
    end
    if (!(d_pmem_read || d_pmem_write) && $urandom_range(0, 99) < d_rate) begin
      if ($urandom_range(0, 1) == 1) begin
        d_pmem_write = 1'b1;
        d_pmem_wdata = rand_line();
      end else begin
        d_pmem_read = 1'b1;
      end
      d_pmem_address = rand_addr();
    end
    if (inj_i) begin
      i_pmem_read = 1'b1; i_pmem_address = inj_i_addr; inj_i = 1'b0;
    end
    if (inj_d) begin
      d_pmem_read    = !inj_d_write;
      d_pmem_write   = inj_d_write;
      d_pmem_address = inj_d_addr;
      d_pmem_wdata   = inj_d_wdata;
      inj_d          = 1'b0;
    end
    if (inj_addr_change) begin
      d_pmem_address  = inj_new_addr;
      inj_addr_change = 1'b0;
    end
  endtask

  task automatic sample_and_check();
    bit d_req, exp_ir, exp_dr;
    d_req  = d_pmem_read || d_pmem_write;
    check("pmem_read",  pmem_read,  m_owner != 0 && !m_write);
    check("pmem_write", pmem_write, m_owner != 0 && m_write);
    if (m_owner != 0) check("pmem_address", pmem_address, m_addr);
    if (m_owner != 0 && m_write) check("pmem_wdata", pmem_wdata, m_wdata);
    exp_ir = (m_owner == 1) && pmem_resp;
    exp_dr = (m_owner == 2) && pmem_resp;
    check("i_pmem_resp", i_pmem_resp, exp_ir);
    check("d_pmem_resp", d_pmem_resp, exp_dr);
    check("i_rdata_pass", i_pmem_rdata, pmem_rdata);
    check("d_rdata_pass", d_pmem_rdata, pmem_rdata);
    if (exp_ir) check("i_line", i_pmem_rdata, model_rd(m_addr));
    if (exp_dr && !m_write) check("d_line", d_pmem_rdata, model_rd(m_addr));
    check("arb_conflict", arb_conflict, m_owner == 0 && i_pmem_read && d_req);

    if (arb_conflict) conflict_seen = 1'b1;
    i_done = i_pmem_resp;
    d_done = d_pmem_resp;
    if (i_pmem_resp) begin resp_log.push_back(RI); i_last_line = i_pmem_rdata; end
    if (d_pmem_resp) begin resp_log.push_back(RD); d_last_line = d_pmem_rdata; end

    if (m_owner == 0) begin
      if (d_req && !(i_pmem_read && m_starve == LIMIT)) begin
        m_owner = 2;
        m_addr  = d_pmem_address;
        m_write = d_pmem_write;
        if (d_pmem_write) m_wdata = d_pmem_wdata;
        m_starve = i_pmem_read ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
      end else if (i_pmem_read) begin
        m_owner  = 1;
        m_addr   = i_pmem_address;
        m_write  = 1'b0;
        m_starve = 0;
      end
    end else if (pmem_resp) begin
      if (m_write) model_mem[m_addr] = m_wdata;
      m_owner = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #2 drive();
    #3 sample_and_check();
  endtask

  task automatic run_until_resps(input string tag, input int n);
    int budget = 200;
    while (resp_log.size() < n && budget > 0) begin
      cycle();
      budget--;
    end
    check({tag, "_timeout"}, resp_log.size() >= n, 1'b1);
  endtask

  task automatic wait_idle();
    int budget = 300;
    while ((m_owner != 0 || i_pmem_read || d_pmem_read || d_pmem_write) && budget > 0) begin
      cycle();
      budget--;
    end
    check("drain_timeout", budget > 0, 1'b1);
  endtask

  initial begin
    byte t4_exp [6] = '{RD, RD, RD, RD, RI, RD};
    reset = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #5;
    check("rst_pmem_read",  pmem_read,    1'b0);
    check("rst_pmem_write", pmem_write,   1'b0);
    check("rst_address",    pmem_address, 16'h0);
    check("rst_wdata",      pmem_wdata,   128'h0);
    check("rst_resps",      {i_pmem_resp, d_pmem_resp, arb_conflict}, 3'b000);
    reset = 1'b0;

    // I-cache read alone.
    fixed_lat = 5;
    inj_i = 1'b1; inj_i_addr = 16'h1230;
    resp_log.delete();
    run_until_resps("t1", 1);
    check("t1_owner", resp_log[0], RI);
    check("t1_line", i_last_line, seed_line(16'h1230));
    wait_idle();

    // D writeback then an immediate D read of the same line.
    inj_d = 1'b1; inj_d_write = 1'b1; inj_d_addr = 16'h4440; inj_d_wdata = T2_WDATA;
    resp_log.delete();
    run_until_resps("t2w", 1);
    inj_d = 1'b1; inj_d_write = 1'b0; inj_d_addr = 16'h4440;
    run_until_resps("t2r", 2);
    check("t2_owner", resp_log[1], RD);
    check("t2_readback", d_last_line, T2_WDATA);
    wait_idle();

    // Simultaneous I and D reads.
    conflict_seen = 1'b0;
    inj_i = 1'b1; inj_i_addr = 16'h2220;
    inj_d = 1'b1; inj_d_write = 1'b0; inj_d_addr = 16'h3330;
    resp_log.delete();
    run_until_resps("t3", 2);
    check("t3_conflict", conflict_seen, 1'b1);
    check("t3_first",  resp_log[0], RD);
    check("t3_second", resp_log[1], RI);
    check("t3_i_line", i_last_line, seed_line(16'h2220));
    wait_idle();

    // I held while D re-requests continuously: starvation limit forces an I grant.
    fixed_lat = 2; d_rate = 100;
    inj_i = 1'b1; inj_i_addr = 16'h7770;
    inj_d = 1'b1; inj_d_write = 1'b0; inj_d_addr = 16'h0080;
    resp_log.delete();
    run_until_resps("t4", 6);
    d_rate = 0;
    for (int k = 0; k < 6; k++) check($sformatf("t4_grant%0d", k), resp_log[k], t4_exp[k]);
    wait_idle();

    // D address changes mid-transaction; memory keeps the latched address.
    fixed_lat = 6;
    inj_d = 1'b1; inj_d_write = 1'b0; inj_d_addr = 16'h4440;
    resp_log.delete();
    cycle();
    cycle();
    inj_addr_change = 1'b1; inj_new_addr = 16'h9990;
    cycle();
    check("t5_addr", pmem_address, 16'h4440);
    run_until_resps("t5", 1);
    wait_idle();

    // Reset during a D writeback with an I read pending behind it.
    fixed_lat = 8;
    inj_d = 1'b1; inj_d_write = 1'b1; inj_d_addr = 16'h5550; inj_d_wdata = rand_line();
    cycle();
    inj_i = 1'b1; inj_i_addr = 16'h6660;
    cycle();
    cycle();
    check("t6_pre_write", pmem_write, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_write_drop", pmem_write, 1'b0);
    check("t6_read_drop",  pmem_read,  1'b0);
    check("t6_no_resp",    {i_pmem_resp, d_pmem_resp}, 2'b00);
    check("t6_addr_clr",   pmem_address, 16'h0);
    m_owner = 0; m_starve = 0;
    mem_cnt = 0; pmem_resp = 1'b0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_done = 1'b0;
    #2 reset = 1'b0;
    resp_log.delete();
    sample_and_check();
    run_until_resps("t6", 1);
    check("t6_owner", resp_log[0], RI);
    check("t6_line",  i_last_line, seed_line(16'h6660));
    wait_idle();

    // Random traffic with moving requester inputs and random memory latency.
    fixed_lat = 0; mutate = 1'b1; i_rate = 25; d_rate = 25;
    repeat (3000) cycle();
    i_rate = 0; d_rate = 0; mutate = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
